// File: rtl/l15_req_port_arbiter.sv
// N-port request arbiter onto the single L1.5 request channel, with per-port credit limits.
// Optional starvation guard compiled in with L15_ARB_STARVATION_GUARD_EN.
module l15_req_port_arbiter #(
  parameter int NumPorts       = 6,
  parameter int ReqWidth       = 128,
  parameter int MaxOutstanding = 4,
  parameter int RoundRobin     = 0,
  parameter int StarveTh       = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_l,
  input  logic [NumPorts-1:0]          req_valid_i,
  output logic [NumPorts-1:0]          req_ready_o,
  input  logic [NumPorts*ReqWidth-1:0] req_data_i,
  output logic                         l15_val_o,
  output logic [ReqWidth-1:0]          l15_req_o,
  output logic [$clog2(NumPorts)-1:0]  l15_port_o,
  input  logic                         l15_ack_i,
  input  logic                         rtrn_val_i,
  input  logic [$clog2(NumPorts)-1:0]  rtrn_port_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int PortW = $clog2(NumPorts);
  localparam int CntW  = $clog2(MaxOutstanding + 1);

  if (StarveTh < 2 || StarveTh > 255 || MaxOutstanding < 1 || MaxOutstanding > 15) begin : g_bad_param
    $error("l15_req_port_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, PEND} state_e;

  state_e              state_q, state_d;
  logic [ReqWidth-1:0] l15_req_q, l15_req_d;
  logic [PortW-1:0]    l15_port_q, l15_port_d;
  logic [PortW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q [NumPorts];
  logic [CntW-1:0]     cnt_d [NumPorts];
  logic                err_q, err_d;

  logic [NumPorts-1:0] elig;
  logic [NumPorts-1:0] inc_v, dec_v;
  logic [PortW-1:0]    win;
  logic                found;

  function automatic logic [CntW-1:0] cnt_sat_inc(input logic [CntW-1:0] c);
    cnt_sat_inc = (c == CntW'(MaxOutstanding)) ? c : c + CntW'(1);
  endfunction

  always_comb begin
    elig = '0;
    for (int p = 0; p < NumPorts; p++)
      elig[p] = req_valid_i[p] && (cnt_q[p] < CntW'(MaxOutstanding));
  end

`ifdef L15_ARB_STARVATION_GUARD_EN
  logic [7:0]          wait_q [NumPorts];
  logic [7:0]          wait_d [NumPorts];
  logic [NumPorts-1:0] starved;

  function automatic logic [7:0] wait_sat_inc(input logic [7:0] w);
    wait_sat_inc = (w == 8'hFF) ? w : w + 8'd1;
  endfunction

  always_comb begin
    starved = '0;
    for (int p = 0; p < NumPorts; p++)
      starved[p] = elig[p] && (wait_q[p] >= 8'(StarveTh));
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      wait_d[p] = wait_q[p];
      if (!req_valid_i[p] || req_ready_o[p])
        wait_d[p] = '0;
      else if (elig[p])
        wait_d[p] = wait_sat_inc(wait_q[p]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      for (int p = 0; p < NumPorts; p++) wait_q[p] <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) wait_q[p] <= wait_d[p];
    end
  end
`endif

  // Winner selection; a starved port (guard builds only) overrides the base policy.
  always_comb begin : winner_sel
    logic [PortW:0] sum;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    if (RoundRobin != 0) begin
      for (int i = 0; i < NumPorts; i++) begin
        sum = {1'b0, ptr_q} + (PortW+1)'(i);
        if (sum >= (PortW+1)'(NumPorts)) sum = sum - (PortW+1)'(NumPorts);
        if (!found && elig[sum[PortW-1:0]]) begin
          found = 1'b1;
          win   = sum[PortW-1:0];
        end
      end
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (!found && elig[p]) begin
          found = 1'b1;
          win   = PortW'(p);
        end
      end
    end
`ifdef L15_ARB_STARVATION_GUARD_EN
    if (|starved) begin
      for (int p = NumPorts - 1; p >= 0; p--)
        if (starved[p]) win = PortW'(p);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    l15_req_d   = l15_req_q;
    l15_port_d  = l15_port_q;
    ptr_d       = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_o[win] = 1'b1;
          l15_req_d        = req_data_i[int'(win)*ReqWidth +: ReqWidth];
          l15_port_d       = win;
          ptr_d            = (win == PortW'(NumPorts - 1)) ? '0 : win + PortW'(1);
          state_d          = PEND;
        end
      end
      PEND: begin
        if (l15_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counters: same-cycle ack and return on one port cancel out.
  always_comb begin
    err_d = err_q;
    inc_v = '0;
    dec_v = '0;
    for (int p = 0; p < NumPorts; p++) begin
      inc_v[p] = (state_q == PEND) && l15_ack_i && (l15_port_q == PortW'(p));
      dec_v[p] = rtrn_val_i && (rtrn_port_i == PortW'(p)) && (cnt_q[p] != '0);
      cnt_d[p] = cnt_q[p];
      if (inc_v[p] && !dec_v[p])
        cnt_d[p] = cnt_sat_inc(cnt_q[p]);
      else if (dec_v[p] && !inc_v[p])
        cnt_d[p] = cnt_q[p] - CntW'(1);
      if (rtrn_val_i && (rtrn_port_i == PortW'(p)) && (cnt_q[p] == '0))
        err_d = 1'b1;
    end
    if (rtrn_val_i && ({1'b0, rtrn_port_i} >= (PortW+1)'(NumPorts)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= IDLE;
      l15_req_q  <= '0;
      l15_port_q <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      for (int p = 0; p < NumPorts; p++) cnt_q[p] <= '0;
    end else begin
      state_q    <= state_d;
      l15_req_q  <= l15_req_d;
      l15_port_q <= l15_port_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      for (int p = 0; p < NumPorts; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  always_comb begin
    busy_o = (state_q == PEND);
    for (int p = 0; p < NumPorts; p++)
      if (cnt_q[p] != '0) busy_o = 1'b1;
  end

  assign l15_val_o  = (state_q == PEND);
  assign l15_req_o  = l15_req_q;
  assign l15_port_o = l15_port_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_l15_req_port_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter, checked against an expected-grant queue.
module tb_l15_req_port_arbiter;
  localparam int NP = 6;
  localparam int RW = 128;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    valid    [2];
  logic [NP-1:0]    ready    [2];
  logic             l15_val  [2];
  logic [RW-1:0]    l15_req  [2];
  logic [PW-1:0]    l15_port [2];
  logic             ack      [2];
  logic             rv       [2];
  logic [PW-1:0]    rp       [2];
  logic             busy     [2];
  logic             err      [2];
  logic [NP*RW-1:0] data;

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];

  l15_req_port_arbiter #(.NumPorts(NP), .ReqWidth(RW), .MaxOutstanding(4), .RoundRobin(0), .StarveTh(16)) u_fp (
    .clk_i(clk), .reset_l(reset_l), .req_valid_i(valid[0]), .req_ready_o(ready[0]), .req_data_i(data),
    .l15_val_o(l15_val[0]), .l15_req_o(l15_req[0]), .l15_port_o(l15_port[0]), .l15_ack_i(ack[0]),
    .rtrn_val_i(rv[0]), .rtrn_port_i(rp[0]), .busy_o(busy[0]), .err_o(err[0]));

  l15_req_port_arbiter #(.NumPorts(NP), .ReqWidth(RW), .MaxOutstanding(4), .RoundRobin(1), .StarveTh(16)) u_rr (
    .clk_i(clk), .reset_l(reset_l), .req_valid_i(valid[1]), .req_ready_o(ready[1]), .req_data_i(data),
    .l15_val_o(l15_val[1]), .l15_req_o(l15_req[1]), .l15_port_o(l15_port[1]), .l15_ack_i(ack[1]),
    .rtrn_val_i(rv[1]), .rtrn_port_i(rp[1]), .busy_o(busy[1]), .err_o(err[1]));

  function automatic logic [RW-1:0] pay(input int p);
    pay = {16{8'(p + 17)}};
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] one;
    one = NP'(1);
    onehot = one << p;
  endfunction

  // Entered at a falling edge; serves n grants popped from the expected queue.
  // rmode: 0 no return, 1 return the cycle after the ack, 2 return together with the ack.
  task automatic serve(input int k, input int n, input int hold, input int rmode);
    int e;
    int waited;
    for (int g = 0; g < n; g++) begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      #1;
      waited = 0;
      while (ready[k] == '0 && waited < 20) begin
        @(negedge clk); ack[k] = 1'b0; rv[k] = 1'b0; #1;
        waited++;
      end
      chk("ready_grant", RW'(ready[k]), RW'(onehot(e)));
      @(negedge clk); ack[k] = 1'b0; rv[k] = 1'b0; #1;
      chk("val_pend", RW'(l15_val[k]), RW'(1));
      chk("port", RW'(l15_port[k]), RW'(e));
      chk("data", l15_req[k], pay(e));
      chk("ready_pend", RW'(ready[k]), RW'(0));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); #1;
        chk("hold_val", RW'(l15_val[k]), RW'(1));
        chk("hold_port", RW'(l15_port[k]), RW'(e));
        chk("hold_data", l15_req[k], pay(e));
        chk("hold_ready", RW'(ready[k]), RW'(0));
      end
      ack[k] = 1'b1;
      if (rmode == 2) begin rv[k] = 1'b1; rp[k] = PW'(e); end
      @(negedge clk); ack[k] = 1'b0; rv[k] = 1'b0;
      if (rmode == 1) begin rv[k] = 1'b1; rp[k] = PW'(e); end
    end
  endtask

  task automatic idle_check(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("blocked", RW'(ready[k]), RW'(0));
      @(negedge clk); ack[k] = 1'b0; rv[k] = 1'b0;
    end
  endtask

  task automatic ret(input int k, input int port);
    rv[k] = 1'b1; rp[k] = PW'(port);
    @(negedge clk); rv[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < NP; p++) data[p*RW +: RW] = pay(p);
    for (int k = 0; k < 2; k++) begin
      valid[k] = '0; ack[k] = 1'b0; rv[k] = 1'b0; rp[k] = '0;
    end
    reset_l = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_val", RW'(l15_val[0]), RW'(0));
    chk("rst_req", l15_req[0], RW'(0));
    chk("rst_port", RW'(l15_port[0]), RW'(0));
    chk("rst_ready", RW'(ready[0]), RW'(0));
    chk("rst_busy", RW'(busy[0]), RW'(0));
    chk("rst_err", RW'(err[0]), RW'(0));
    chk("rst_val_rr", RW'(l15_val[1]), RW'(0));
    @(negedge clk); reset_l = 1'b1;
    @(negedge clk);

    // Fixed priority with ports 1,3,5: each drains its four credits in priority order.
    valid[0] = 6'b101010;
    for (int i = 0; i < 4; i++) q0.push_back(1);
    for (int i = 0; i < 4; i++) q0.push_back(3);
    for (int i = 0; i < 4; i++) q0.push_back(5);
    serve(0, 12, 0, 0);
    idle_check(0, 4);
    #1 chk("busy_full", RW'(busy[0]), RW'(1));
    @(negedge clk);

    // Free one port-3 credit, then stall the ack for five cycles.
    ret(0, 3);
    q0.push_back(3);
    serve(0, 1, 5, 0);
    idle_check(0, 2);

    // Port 2 to cnt=3, ack+return together keeps it at 3, so exactly one more grant fits.
    valid[0] = 6'b000100;
    for (int i = 0; i < 5; i++) q0.push_back(2);
    serve(0, 3, 0, 0);
    serve(0, 1, 0, 2);
    serve(0, 1, 0, 0);
    idle_check(0, 3);

    #1 chk("err_clean", RW'(err[0]), RW'(0));
    @(negedge clk);
    ret(0, 4);
    #1 chk("err_zero_rtrn", RW'(err[0]), RW'(1));
    repeat (3) @(negedge clk);
    #1 chk("err_sticky", RW'(err[0]), RW'(1));
    @(negedge clk);

    // Round-robin across all ports, then a sparse set that exercises pointer wrap.
    valid[1] = 6'b111111;
    for (int i = 0; i < 6; i++) q1.push_back(i);
    q1.push_back(0);
    serve(1, 7, 0, 1);
    valid[1] = 6'b010100;
    q1.push_back(2); q1.push_back(4); q1.push_back(2);
    serve(1, 3, 0, 1);
    valid[1] = '0;
    @(negedge clk); rv[1] = 1'b0;
    #1 chk("rr_err_clean", RW'(err[1]), RW'(0));
    @(negedge clk);
    rv[1] = 1'b1; rp[1] = 3'd6;
    @(negedge clk); rv[1] = 1'b0;
    #1 chk("err_bad_port", RW'(err[1]), RW'(1));
    @(negedge clk);

    // Reset during PEND with cnt[0]=2.
    valid[0] = 6'b000001;
    q0.push_back(0); q0.push_back(0);
    serve(0, 2, 0, 0);
    #1 chk("third_grant", RW'(ready[0]), RW'(onehot(0)));
    @(negedge clk); #1;
    chk("pend_before_rst", RW'(l15_val[0]), RW'(1));
    reset_l = 1'b0;
    #1;
    chk("async_rst_val", RW'(l15_val[0]), RW'(0));
    chk("async_rst_busy", RW'(busy[0]), RW'(0));
    chk("rst_clears_err", RW'(err[0]), RW'(0));
    @(negedge clk); reset_l = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(0);
    serve(0, 4, 0, 0);
    idle_check(0, 2);

    // Ports 0 and 5 with port 0 always replenished.
    valid[0] = '0;
    reset_l = 1'b0;
    @(negedge clk); reset_l = 1'b1;
    @(negedge clk);
    valid[0] = 6'b100001;
`ifdef L15_ARB_STARVATION_GUARD_EN
    for (int i = 0; i < 8; i++) q0.push_back(0);
    q0.push_back(5);
    q0.push_back(0);
`else
    for (int i = 0; i < 10; i++) q0.push_back(0);
`endif
    serve(0, 10, 0, 1);
    valid[0] = '0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
